// File: rtl/cdb_arbiter_rr.sv
// Common-data-bus arbiter: grants up to NUM_CDB result producers per cycle and broadcasts them one cycle later.
// Define CDB_ARB_ROUND_ROBIN_EN for round-robin search; otherwise fixed priority, highest index first.
module cdb_arbiter_rr #(
  parameter int N         = 4,
  parameter int NUM_CDB   = 1,
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N-1:0]              req_valid,
  input  logic [N*TAG_WIDTH-1:0]    req_tag,
  input  logic [N*XLEN-1:0]         req_data,
  output logic [N-1:0]              req_ready,
  input  logic                      flush,
  output logic [NUM_CDB-1:0]        cdb_valid,
  output logic [NUM_CDB*TAG_WIDTH-1:0] cdb_tag,
  output logic [NUM_CDB*XLEN-1:0]   cdb_data,
  output logic                      cdb_active
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  logic [TAG_WIDTH-1:0] tag_arr  [N];
  logic [XLEN-1:0]      data_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign tag_arr[i]  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
    assign data_arr[i] = req_data[i*XLEN +: XLEN];
  end

  logic [NUM_CDB-1:0] slot_valid;
  idx_t               slot_idx [NUM_CDB];

`ifdef CDB_ARB_ROUND_ROBIN_EN
  idx_t ptr;
  idx_t last_idx;
  logic any_grant;
`endif

  // Search order walks every unit once; the n-th valid unit found lands on bus n.
  always_comb begin
    int   cnt;
    int   pos;
    idx_t idx;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_ready  = '0;
    slot_valid = '0;
    cnt        = 0;
    pos        = 0;
    idx        = '0;
    for (int k = 0; k < NUM_CDB; k++) slot_idx[k] = '0;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    last_idx  = '0;
    any_grant = 1'b0;
`endif
    for (int j = 0; j < N; j++) begin
`ifdef CDB_ARB_ROUND_ROBIN_EN
      pos = int'(ptr) + j;
      if (pos >= N) pos = pos - N;
`else
      pos = N - 1 - j;
`endif
      idx = idx_t'(pos);
      if (reset_n && !flush && req_valid[idx] && (cnt < NUM_CDB)) begin
        req_ready[idx] = 1'b1;
        for (int k = 0; k < NUM_CDB; k++) begin
          if (k == cnt) begin
            slot_valid[k] = 1'b1;
            slot_idx[k]   = idx;
          end
        end
`ifdef CDB_ARB_ROUND_ROBIN_EN
        last_idx  = idx;
        any_grant = 1'b1;
`endif
        cnt = cnt + 1;
      end
    end
  end

  // Tag/data of an idle bus keep their last value; only valid drops.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else begin
      cdb_valid <= slot_valid;
      for (int k = 0; k < NUM_CDB; k++) begin
        if (slot_valid[k]) begin
          cdb_tag[k*TAG_WIDTH +: TAG_WIDTH] <= tag_arr[slot_idx[k]];
          cdb_data[k*XLEN +: XLEN]          <= data_arr[slot_idx[k]];
        end
      end
    end
  end

`ifdef CDB_ARB_ROUND_ROBIN_EN
  // Pointer moves past the last winner; flush or an idle cycle leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= (last_idx == idx_t'(N - 1)) ? '0 : last_idx + 1'b1;
    end
  end
`endif

  assign cdb_active = |cdb_valid;

endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// Directed bench for cdb_arbiter_rr: a single-bus and a dual-bus instance with hand-computed expectations.
// Expectations follow CDB_ARB_ROUND_ROBIN_EN when defined, fixed priority otherwise.
module tb_cdb_arbiter_rr;
  localparam int N    = 4;
  localparam int XLEN = 32;
  localparam int TW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n;
  logic                flush;
  logic [N-1:0]        v1, v2, rdy1, rdy2;
  logic [N*TW-1:0]     req_tag  = 16'h4321;
  logic [N*XLEN-1:0]   req_data = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};

  logic [0:0]          cv1;
  logic [TW-1:0]       ct1;
  logic [XLEN-1:0]     cd1;
  logic                act1;
  logic [1:0]          cv2;
  logic [2*TW-1:0]     ct2;
  logic [2*XLEN-1:0]   cd2;
  logic                act2;

  int checks = 0;
  int errors = 0;

  cdb_arbiter_rr #(.N(N), .NUM_CDB(1), .XLEN(XLEN), .TAG_WIDTH(TW)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(v1), .req_tag(req_tag), .req_data(req_data),
    .req_ready(rdy1), .flush(flush), .cdb_valid(cv1), .cdb_tag(ct1), .cdb_data(cd1),
    .cdb_active(act1)
  );

  cdb_arbiter_rr #(.N(N), .NUM_CDB(2), .XLEN(XLEN), .TAG_WIDTH(TW)) dut2 (
    .clk(clk), .reset_n(reset_n), .req_valid(v2), .req_tag(req_tag), .req_data(req_data),
    .req_ready(rdy2), .flush(flush), .cdb_valid(cv2), .cdb_tag(ct2), .cdb_data(cd2),
    .cdb_active(act2)
  );

  task automatic do_reset();
    reset_n = 1'b0; v1 = '0; v2 = '0; flush = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; v1 = 4'hF; v2 = 4'hF; flush = 1'b0;
    @(posedge clk); #1;
    checks++; if (rdy1 !== 4'h0) begin errors++; $display("FAIL reset_ready1: got %h expected 0", rdy1); end
    checks++; if (rdy2 !== 4'h0) begin errors++; $display("FAIL reset_ready2: got %h expected 0", rdy2); end
    checks++; if ({cv1, ct1, cd1, act1} !== '0) begin errors++;
      $display("FAIL reset_bus1: valid %h tag %h data %h active %b expected all 0", cv1, ct1, cd1, act1); end
    checks++; if ({cv2, ct2, cd2, act2} !== '0) begin errors++;
      $display("FAIL reset_bus2: valid %h tag %h data %h active %b expected all 0", cv2, ct2, cd2, act2); end
    v1 = '0; v2 = '0; reset_n = 1'b1;
  endtask

  // All four units request at once and each drops its request once accepted.
  task automatic test_sequence();
    logic [3:0] rem, exp_rdy, prev_tag;
    int g;
    do_reset();
    rem = 4'hF;
    prev_tag = '0;
    for (int k = 0; k < 4; k++) begin
`ifdef CDB_ARB_ROUND_ROBIN_EN
      g = k;
`else
      g = 3 - k;
`endif
      v1 = rem; #1;
      exp_rdy = '0; exp_rdy[g] = 1'b1;
      checks++; if (rdy1 !== exp_rdy) begin errors++; $display("FAIL seq_ready[%0d]: got %b expected %b", k, rdy1, exp_rdy); end
      checks++; if (ct1 !== prev_tag) begin errors++; $display("FAIL seq_latency[%0d]: got tag %h expected %h", k, ct1, prev_tag); end
      @(posedge clk); #1;
      checks++; if (cv1 !== 1'b1 || act1 !== 1'b1 || ct1 !== TW'(g + 1) || cd1 !== 32'hD000_0000 + 32'(g)) begin errors++;
        $display("FAIL seq_bus[%0d]: valid %b active %b tag %h data %h expected unit %0d", k, cv1, act1, ct1, cd1, g); end
      prev_tag = TW'(g + 1);
      rem[g] = 1'b0;
    end
    v1 = rem;
    @(posedge clk); #1;
    checks++; if (cv1 !== 1'b0 || act1 !== 1'b0 || ct1 !== prev_tag) begin errors++;
      $display("FAIL seq_idle: valid %b active %b tag %h expected 0 0 %h", cv1, act1, ct1, prev_tag); end
  endtask

  // Pointer wrap (round-robin) or repeated top-priority wins (fixed).
  task automatic test_wrap();
    logic [3:0] vs [4];
    int gs [4];
    logic [3:0] exp_rdy;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    vs[0] = 4'b0100; vs[1] = 4'b0101; vs[2] = 4'b0101; vs[3] = 4'b0001;
    gs[0] = 2;       gs[1] = 0;       gs[2] = 2;       gs[3] = 0;
`else
    vs[0] = 4'b0100; vs[1] = 4'b0101; vs[2] = 4'b0001; vs[3] = 4'b0011;
    gs[0] = 2;       gs[1] = 2;       gs[2] = 0;       gs[3] = 1;
`endif
    do_reset();
    for (int k = 0; k < 4; k++) begin
      v1 = vs[k]; #1;
      exp_rdy = '0; exp_rdy[gs[k]] = 1'b1;
      checks++; if (rdy1 !== exp_rdy) begin errors++; $display("FAIL wrap_ready[%0d]: got %b expected %b", k, rdy1, exp_rdy); end
      @(posedge clk); #1;
      checks++; if (cv1 !== 1'b1 || ct1 !== TW'(gs[k] + 1)) begin errors++;
        $display("FAIL wrap_bus[%0d]: valid %b tag %h expected 1 %h", k, cv1, ct1, TW'(gs[k] + 1)); end
    end
    v1 = '0;
  endtask

  // Two simultaneous requesters on a single bus: the loser keeps valid high and wins next.
  task automatic test_hold();
    int g0, g1;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    g0 = 1; g1 = 2;
`else
    g0 = 2; g1 = 1;
`endif
    do_reset();
    v1 = 4'b0110; #1;
    checks++; if (rdy1 !== 4'(1 << g0)) begin errors++; $display("FAIL hold_ready0: got %b expected unit %0d", rdy1, g0); end
    @(posedge clk); #1;
    checks++; if (ct1 !== TW'(g0 + 1) || cv1 !== 1'b1) begin errors++; $display("FAIL hold_bus0: tag %h valid %b expected unit %0d", ct1, cv1, g0); end
    v1 = 4'(1 << g1); #1;
    checks++; if (rdy1 !== 4'(1 << g1)) begin errors++; $display("FAIL hold_ready1: got %b expected unit %0d", rdy1, g1); end
    @(posedge clk); #1;
    checks++; if (ct1 !== TW'(g1 + 1) || cd1 !== 32'hD000_0000 + 32'(g1) || cv1 !== 1'b1) begin errors++;
      $display("FAIL hold_bus1: tag %h data %h valid %b expected unit %0d", ct1, cd1, cv1, g1); end
    v1 = '0;
  endtask

  task automatic test_multi_bus();
    logic [3:0] vs [5];
    logic [3:0] rdys [5];
    logic [1:0] cvs [5];
    logic [3:0] t0s [5];
    logic [3:0] t1s [5];
    logic [31:0] d0, d1;
    vs[0] = 4'b0001; vs[1] = 4'b1011; vs[2] = 4'b1001; vs[3] = 4'b0100; vs[4] = 4'b0000;
    rdys[0] = 4'b0001; rdys[1] = 4'b1010; rdys[2] = 4'b1001; rdys[3] = 4'b0100; rdys[4] = 4'b0000;
    cvs[0] = 2'b01; cvs[1] = 2'b11; cvs[2] = 2'b11; cvs[3] = 2'b01; cvs[4] = 2'b00;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    t0s[0] = 4'd1; t0s[1] = 4'd2; t0s[2] = 4'd1; t0s[3] = 4'd3; t0s[4] = 4'd3;
    t1s[0] = 4'd0; t1s[1] = 4'd4; t1s[2] = 4'd4; t1s[3] = 4'd4; t1s[4] = 4'd4;
`else
    t0s[0] = 4'd1; t0s[1] = 4'd4; t0s[2] = 4'd4; t0s[3] = 4'd3; t0s[4] = 4'd3;
    t1s[0] = 4'd0; t1s[1] = 4'd2; t1s[2] = 4'd1; t1s[3] = 4'd1; t1s[4] = 4'd1;
`endif
    do_reset();
    for (int k = 0; k < 5; k++) begin
      v2 = vs[k]; #1;
      checks++; if (rdy2 !== rdys[k]) begin errors++; $display("FAIL mb_ready[%0d]: got %b expected %b", k, rdy2, rdys[k]); end
      @(posedge clk); #1;
      d0 = (t0s[k] == 0) ? 32'h0 : 32'hD000_0000 + 32'(t0s[k]) - 32'd1;
      d1 = (t1s[k] == 0) ? 32'h0 : 32'hD000_0000 + 32'(t1s[k]) - 32'd1;
      checks++; if (cv2 !== cvs[k] || act2 !== (cvs[k] != 2'b00)) begin errors++;
        $display("FAIL mb_valid[%0d]: valid %b active %b expected %b", k, cv2, act2, cvs[k]); end
      checks++; if (ct2 !== {t1s[k], t0s[k]} || cd2 !== {d1, d0}) begin errors++;
        $display("FAIL mb_payload[%0d]: tag %h data %h expected tag %h data %h", k, ct2, cd2, {t1s[k], t0s[k]}, {d1, d0}); end
    end
    v2 = '0;
  endtask

  task automatic test_flush();
    int g;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    g = 1;
`else
    g = 3;
`endif
    do_reset();
    v1 = 4'b0001; #1;
    @(posedge clk); #1;
    checks++; if (cv1 !== 1'b1 || ct1 !== 4'd1) begin errors++; $display("FAIL flush_pre: valid %b tag %h expected 1 1", cv1, ct1); end
    v1 = 4'b1111; flush = 1'b1; #1;
    checks++; if (rdy1 !== 4'b0000) begin errors++; $display("FAIL flush_ready: got %b expected 0000", rdy1); end
    @(posedge clk); #1;
    checks++; if (cv1 !== 1'b0 || act1 !== 1'b0 || ct1 !== 4'd1) begin errors++;
      $display("FAIL flush_bus: valid %b active %b tag %h expected 0 0 1", cv1, act1, ct1); end
    flush = 1'b0; #1;
    checks++; if (rdy1 !== 4'(1 << g)) begin errors++; $display("FAIL flush_ptr: got %b expected unit %0d", rdy1, g); end
    @(posedge clk); #1;
    checks++; if (cv1 !== 1'b1 || ct1 !== TW'(g + 1)) begin errors++; $display("FAIL flush_after: valid %b tag %h expected unit %0d", cv1, ct1, g); end
    v1 = '0;
  endtask

  task automatic test_async_reset();
    int g;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    g = 1;
`else
    g = 2;
`endif
    do_reset();
    v1 = 4'b0010; #1;
    @(posedge clk); #1;
    checks++; if (cv1 !== 1'b1 || act1 !== 1'b1) begin errors++; $display("FAIL ares_pre: valid %b active %b expected 1 1", cv1, act1); end
    v1 = 4'b0110; #1;
    reset_n = 1'b0; #1;
    checks++; if (cv1 !== 1'b0 || act1 !== 1'b0 || ct1 !== 4'd0 || cd1 !== 32'd0 || rdy1 !== 4'd0) begin errors++;
      $display("FAIL ares_now: valid %b active %b tag %h data %h ready %b expected all 0", cv1, act1, ct1, cd1, rdy1); end
    #1; reset_n = 1'b1; #1;
    checks++; if (rdy1 !== 4'(1 << g)) begin errors++; $display("FAIL ares_ptr: got %b expected unit %0d", rdy1, g); end
    @(posedge clk); #1;
    checks++; if (cv1 !== 1'b1 || ct1 !== TW'(g + 1)) begin errors++; $display("FAIL ares_after: valid %b tag %h expected unit %0d", cv1, ct1, g); end
    v1 = '0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_wrap();
    test_hold();
    test_multi_bus();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
